// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: AXI4-Stream video test-pattern source.
// Emits whole frames of H_PIXEL_COUNT x V_PIXEL_COUNT pixels with tuser[0]
// on the first pixel of a frame and tlast on the last pixel of every line.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame in progress; waiting for enable_i
// ST_ACTIVE | frame in progress; first cycle primes the output register,
//           | afterwards one pixel per handshake until (H-1, V-1)
module lcd_pattern_gen #(
  parameter int H_PIXEL_COUNT = 8,
  parameter int V_PIXEL_COUNT = 4,
  parameter int DATA_WIDTH    = 18,
  parameter int USER_WIDTH    = 1,
  parameter int CHECKER_LOG2  = 1,
  parameter int BAR_WIDTH     = 1
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [1:0]            pattern_i,
  input  logic [DATA_WIDTH-1:0] color_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  localparam int CW = DATA_WIDTH / 3;
  localparam int XW = $clog2(H_PIXEL_COUNT);
  localparam int YW = (V_PIXEL_COUNT > 1) ? $clog2(V_PIXEL_COUNT) : 1;
  localparam int BW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam int GW = (XW < CW) ? XW : CW;

  localparam logic [XW-1:0] X_LAST   = XW'(H_PIXEL_COUNT - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_PIXEL_COUNT - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_WIDTH - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]            state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [BW-1:0]         bar_cnt;
  logic [2:0]            bar_idx;
  logic [1:0]            pat;
  logic [DATA_WIDTH-1:0] color;

  logic                  hs;
  logic                  frame_end;
  logic                  load;
  logic [XW-1:0]         nx;
  logic [YW-1:0]         ny;
  logic [BW-1:0]         nbar_cnt;
  logic [2:0]            nbar_idx;
  logic [1:0]            npat;
  logic [DATA_WIDTH-1:0] ncolor;

  logic [DATA_WIDTH-1:0] pixel;
  logic [USER_WIDTH-1:0] user_next;
  logic [CW-1:0]         grad;
  logic                  chk;
  logic [2:0]            bar_c;

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign frame_end = hs && (x == X_LAST) && (y == Y_LAST);

  // Next pixel position: prime, advance along the line, wrap, or restart the frame.
  always_comb begin
    load     = 1'b0;
    nx       = x;
    ny       = y;
    nbar_cnt = bar_cnt;
    nbar_idx = bar_idx;
    npat     = pat;
    ncolor   = color;
    if (state == ST_ACTIVE) begin
      if (!m_axis_tvalid) begin
        load = 1'b1;
      end else if (hs) begin
        if ((x == X_LAST) && (y == Y_LAST)) begin
          if (enable_i) begin
            // Back-to-back frame: relatch the inputs and present (0,0) with no bubble.
            load     = 1'b1;
            nx       = '0;
            ny       = '0;
            nbar_cnt = '0;
            nbar_idx = '0;
            npat     = pattern_i;
            ncolor   = color_i;
          end
        end else begin
          load = 1'b1;
          if (x == X_LAST) begin
            nx       = '0;
            ny       = y + YW'(1);
            nbar_cnt = '0;
            nbar_idx = '0;
          end else begin
            nx = x + XW'(1);
            if (bar_cnt == BAR_LAST) begin
              nbar_cnt = '0;
              nbar_idx = bar_idx + 3'd1;
            end else begin
              nbar_cnt = bar_cnt + BW'(1);
            end
          end
        end
      end
    end
  end

  // Pixel value for the next position, using the latched pattern and colour.
  always_comb begin
    grad  = CW'(nx[GW-1:0]);
    chk   = (|(nx & (XW'(1) << CHECKER_LOG2))) ^ (|(ny & (YW'(1) << CHECKER_LOG2)));
    bar_c = 3'd7 - nbar_idx;
    pixel = '0;
    case (npat)
      2'd0: pixel = ncolor;
      2'd1: pixel = {grad, grad, grad};
      2'd2: pixel = chk ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
      // bar_c[2] drives green and bar_c[1] red so the bars run
      // white, yellow, cyan, green, magenta, red, blue, black.
      default: pixel = {{CW{bar_c[1]}}, {CW{bar_c[2]}}, {CW{bar_c[0]}}};
    endcase
    user_next    = '0;
    user_next[0] = (nx == '0) && (ny == '0);
  end

  // Frame sequencing and registered AXI4-Stream outputs.
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      x             <= '0;
      y             <= '0;
      bar_cnt       <= '0;
      bar_idx       <= '0;
      pat           <= '0;
      color         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      frame_done_o <= frame_end;
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            state   <= ST_ACTIVE;
            x       <= '0;
            y       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            pat     <= pattern_i;
            color   <= color_i;
          end
        end
        default: begin
          if (load) begin
            x             <= nx;
            y             <= ny;
            bar_cnt       <= nbar_cnt;
            bar_idx       <= nbar_idx;
            pat           <= npat;
            color         <= ncolor;
            m_axis_tdata  <= pixel;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (nx == X_LAST);
            m_axis_tuser  <= user_next;
            busy_o        <= 1'b1;
          end else if (frame_end) begin
            state         <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            busy_o        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Scoreboard bench for lcd_pattern_gen with default parameters (8x4, 18-bit).
module tb_lcd_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern;
  logic [17:0] color;
  logic [17:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [0:0]  tuser;
  logic        busy;
  logic        frame_done;

  lcd_pattern_gen dut (
    .aclk_i        (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .pattern_i     (pattern),
    .color_i       (color),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .m_axis_tuser  (tuser),
    .busy_o        (busy),
    .frame_done_o  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] data;
    logic        last;
    logic        user;
    logic        eof;
    logic        gap;
  } beat_t;

  beat_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int beats = 0;
  int cyc = 0;
  int prev_hs = -10;
  int fd_count = 0;
  logic fd_exp = 1'b0;
  logic stalled = 1'b0;
  logic [17:0] h_data;
  logic h_last;
  logic h_user;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] pix(input int pat, input logic [17:0] col, input int x, input int y);
    case (pat)
      0: return col;
      1: return 18'((x % 64) * 32'h1041);
      2: return (((x >> 1) ^ (y >> 1)) & 1) != 0 ? 18'h3FFFF : 18'h00000;
      default: begin
        case (x)
          0: return 18'h3FFFF;
          1: return 18'h3FFC0;
          2: return 18'h00FFF;
          3: return 18'h00FC0;
          4: return 18'h3F03F;
          5: return 18'h3F000;
          6: return 18'h0003F;
          default: return 18'h00000;
        endcase
      end
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [17:0] col, input bit gap, input int n);
    beat_t b;
    int k;
    k = 0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (k < n) begin
          b.data = pix(pat, col, x, y);
          b.last = (x == 7);
          b.user = (x == 0) && (y == 0);
          b.eof  = (x == 7) && (y == 3);
          b.gap  = gap && (x == 0) && (y == 0);
          sb.push_back(b);
        end
        k++;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability and frame_done.
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    check("frame_done", frame_done, fd_exp);
    fd_exp = 1'b0;
    if (frame_done) fd_count++;
    if (stalled && !rst) begin
      check("stall_valid", tvalid, 1);
      check("stall_data", tdata, h_data);
      check("stall_last", tlast, h_last);
      check("stall_user", tuser, h_user);
    end
    stalled = tvalid && !tready && !rst;
    h_data  = tdata;
    h_last  = tlast;
    h_user  = tuser[0];
    if (tvalid && tready && !rst) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got data 0x%0h expected no beat", tdata);
      end else begin
        b = sb.pop_front();
        check("beat_data", tdata, b.data);
        check("beat_last", tlast, b.last);
        check("beat_user", tuser, b.user);
        if (b.gap) check("no_bubble", cyc - prev_hs, 1);
        fd_exp = b.eof;
      end
      prev_hs = cyc;
      beats++;
    end
  end

  task automatic run(input int budget, input bit rnd);
    int i;
    i = 0;
    while (sb.size() != 0 && i < budget) begin
      @(posedge clk); #1;
      if (rnd) tready = 1'($urandom_range(0, 1));
      i++;
    end
    tready = 1'b1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid", tvalid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int i;
    i = 0;
    while (beats < target && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (beats < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL beat_wait_timeout: got %0d beats expected %0d", beats, target);
    end
  endtask

  task automatic start_frame();
    enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int fd0;
    int base;
    rst = 1'b1;
    enable = 1'b1;
    pattern = 2'd0;
    color = 18'h2AAAA;
    tready = 1'b1;

    // Reset values while enable is held high
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", tvalid, 0);
    check("rst_data", tdata, 0);
    check("rst_last", tlast, 0);
    check("rst_user", tuser, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);

    // Latency after release, then a full solid frame
    push_frame(0, 18'h2AAAA, 1'b0, 32);
    fd0 = fd_count;
    rst = 1'b0;
    @(posedge clk); #1;
    check("lat_pre_valid", tvalid, 0);
    @(posedge clk); #1;
    check("lat_valid", tvalid, 1);
    check("lat_busy", busy, 1);
    check("first_user", tuser, 1);
    check("first_last", tlast, 0);
    check("first_data", tdata, 18'h2AAAA);
    enable = 1'b0;
    run(200, 1'b0);
    check("solid_done_count", fd_count - fd0, 1);

    // Gradient under random backpressure
    pattern = 2'd1;
    push_frame(1, 18'h0, 1'b0, 32);
    fd0 = fd_count;
    start_frame();
    run(2000, 1'b1);
    check("grad_done_count", fd_count - fd0, 1);

    // Checkerboard with enable dropped at beat 5
    pattern = 2'd2;
    push_frame(2, 18'h0, 1'b0, 32);
    fd0 = fd_count;
    base = beats;
    enable = 1'b1;
    wait_beats(base + 5, 100);
    enable = 1'b0;
    run(200, 1'b0);
    check("chk_beats", beats - base, 32);
    check("chk_done_count", fd_count - fd0, 1);

    // Colour bars
    pattern = 2'd3;
    push_frame(3, 18'h0, 1'b0, 32);
    start_frame();
    run(200, 1'b0);

    // Back-to-back frames with a mid-frame pattern change
    pattern = 2'd0;
    color = 18'h12345;
    push_frame(0, 18'h12345, 1'b0, 32);
    push_frame(1, 18'h0, 1'b1, 32);
    fd0 = fd_count;
    base = beats;
    enable = 1'b1;
    wait_beats(base + 10, 200);
    pattern = 2'd1;
    wait_beats(base + 40, 200);
    enable = 1'b0;
    run(300, 1'b0);
    check("b2b_done_count", fd_count - fd0, 2);

    // Reset at beat 13, then a clean frame from (0,0)
    pattern = 2'd0;
    color = 18'h15A5A;
    push_frame(0, 18'h15A5A, 1'b0, 13);
    base = beats;
    enable = 1'b1;
    wait_beats(base + 13, 200);
    rst = 1'b1;
    tready = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_user", tuser, 0);
    check("midrst_last", tlast, 0);
    check("midrst_data", tdata, 0);
    check("midrst_queue", sb.size(), 0);
    push_frame(0, 18'h15A5A, 1'b0, 32);
    rst = 1'b0;
    tready = 1'b1;
    start_frame();
    run(200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
